// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Opcode encodings and FSM state type for the sequential
//                ALU / multiply-divide execution unit.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SLL   = 4'b0001;
    localparam logic [3:0] OP_SLT   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b0111;
    localparam logic [3:0] OP_SUB   = 4'b1000;
    localparam logic [3:0] OP_MUL   = 4'b1001;
    localparam logic [3:0] OP_MULHU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_REMU  = 4'b1100;
    localparam logic [3:0] OP_SRA   = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_iter
//  Description : Iterative shift-add multiplier / restoring divider, one bit
//                per cycle over WIDTH cycles, start/done pulse interface.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    logic             r_busy;
    logic             r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opb;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_nxt_hi;
    logic [WIDTH-1:0] w_nxt_lo;

    // hi:lo is the 2*WIDTH accumulator: product for multiply, remainder:quotient for divide
    always_comb begin
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
        w_shift   = {r_hi, r_lo[WIDTH-1]};
        w_trial   = w_shift - {1'b0, r_opb};
        w_ge      = ~w_trial[WIDTH];
        if (r_div) begin
            w_nxt_hi = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
            w_nxt_lo = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_nxt_hi = w_mul_sum[WIDTH:1];
            w_nxt_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    // results are presented combinationally during the final iteration cycle
    assign done   = r_busy && (r_cnt == C_LAST);
    assign res_lo = w_nxt_lo;
    assign res_hi = w_nxt_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_div  <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_opb  <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_div  <= is_div;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= a;
            r_opb  <= b;
        end else if (r_busy) begin
            r_hi  <= w_nxt_hi;
            r_lo  <= w_nxt_lo;
            r_cnt <= r_cnt + CNT_W'(1);
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule : alu_muldiv_iter
`default_nettype wire

// File: rtl/alu_seq_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_mdu
//  Description : Handshaked execution unit: single-cycle ALU ops plus
//                iterative MUL/MULHU/DIVU/REMU, registered result and flags.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             sf,
    output logic             cf,
    output logic             of
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_zf;
    logic             r_sf;
    logic             r_cf;
    logic             r_of;

    logic             w_accept;
    logic             w_is_md;
    logic             w_is_div;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0] w_res;
    logic             w_cf;
    logic             w_of;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_lo;
    logic [WIDTH-1:0] w_md_hi;
    logic [WIDTH-1:0] w_md_res;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_is_md   = is_muldiv(op);
    assign w_is_div  = (op == OP_DIVU) || (op == OP_REMU);
    assign w_shamt   = b[SHAMT_W-1:0];

    always_comb begin
        w_sum = {1'b0, a} + {1'b0, b};
        w_dif = {1'b0, a} - {1'b0, b};
        w_res = '0;
        w_cf  = 1'b0;
        w_of  = 1'b0;
        case (op)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_cf  = w_sum[WIDTH];
                w_of  = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_dif[WIDTH-1:0];
                w_cf  = w_dif[WIDTH];
                w_of  = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL:  w_res = a << w_shamt;
            OP_SRL:  w_res = a >> w_shamt;
            OP_SRA:  w_res = $unsigned($signed(a) >>> w_shamt);
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_XOR:  w_res = a ^ b;
            OP_OR:   w_res = a | b;
            OP_AND:  w_res = a & b;
            default: w_res = '0;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_accept && w_is_md),
        .is_div (w_is_div),
        .a      (a),
        .b      (b),
        .done   (w_md_done),
        .res_lo (w_md_lo),
        .res_hi (w_md_hi)
    );

    // low half holds product-low / quotient, high half holds product-high / remainder
    assign w_md_res = ((r_op == OP_MUL) || (r_op == OP_DIVU)) ? w_md_lo : w_md_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_md ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (w_md_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_result <= '0;
            r_zf     <= 1'b0;
            r_sf     <= 1'b0;
            r_cf     <= 1'b0;
            r_of     <= 1'b0;
        end else if (w_accept) begin
            r_op <= op;
            if (!w_is_md) begin
                r_result <= w_res;
                r_zf     <= (w_res == '0);
                r_sf     <= w_res[WIDTH-1];
                r_cf     <= w_cf;
                r_of     <= w_of;
            end
        end else if ((r_state == ST_BUSY) && w_md_done) begin
            r_result <= w_md_res;
            r_zf     <= (w_md_res == '0);
            r_sf     <= w_md_res[WIDTH-1];
            r_cf     <= 1'b0;
            r_of     <= 1'b0;
        end
    end

    assign result = r_result;
    assign zf     = r_zf;
    assign sf     = r_sf;
    assign cf     = r_cf;
    assign of     = r_of;

endmodule : alu_seq_mdu
`default_nettype wire

// File: tb/tb_alu_seq_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq_mdu
//  Description : Directed vector bench for alu_seq_mdu (WIDTH=32).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_seq_mdu;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zf;
    logic             sf;
    logic             cf;
    logic             of;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_seq_mdu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zf        (zf),
        .sf        (sf),
        .cf        (cf),
        .of        (of)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;   // {zf, sf, cf, of}
        int          lat;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                          input logic [31:0] res_e, input logic [3:0] fl_e, input int lat_e,
                          input string name);
        int lat;
        @(negedge clk);
        check({name, " in_ready"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        op       = op_i;
        a        = a_i;
        b        = b_i;
        @(negedge clk);
        in_valid = 1'b0;
        op       = 4'h0;
        a        = $urandom;
        b        = $urandom;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(lat_e));
        check({name, " result"}, 64'(result), 64'(res_e));
        check({name, " flags"}, 64'({zf, sf, cf, of}), 64'(fl_e));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " consumed"}, 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] hold_res;
        logic [3:0]  hold_fl;
        int          lat;

        //            op       a             b             res           {z,s,c,o} lat
        vecs[0]  = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101, 1};
        vecs[1]  = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010, 1};
        vecs[2]  = '{4'b1000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0110, 1};
        vecs[3]  = '{4'b1000, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001, 1};
        vecs[4]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 4'b0000, 1};
        vecs[5]  = '{4'b0011, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 4'b1000, 1};
        vecs[6]  = '{4'b1101, 32'h80000000, 32'h00000024, 32'hF8000000, 4'b0100, 1};
        vecs[7]  = '{4'b0001, 32'h00000001, 32'h0000001F, 32'h80000000, 4'b0100, 1};
        vecs[8]  = '{4'b0101, 32'h80000000, 32'h00000021, 32'h40000000, 4'b0000, 1};
        vecs[9]  = '{4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000, 1};
        vecs[10] = '{4'b0110, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000, 1};
        vecs[11] = '{4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0100, 1};
        vecs[12] = '{4'b1110, 32'h00000005, 32'h00000003, 32'h00000000, 4'b1000, 1};
        vecs[13] = '{4'b1001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 4'b0100, 33};
        vecs[14] = '{4'b1010, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 4'b0000, 33};
        vecs[15] = '{4'b1011, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 4'b0100, 33};
        vecs[16] = '{4'b1100, 32'h00000007, 32'h00000000, 32'h00000007, 4'b0000, 33};
        vecs[17] = '{4'b1011, 32'h00000064, 32'h00000007, 32'h0000000E, 4'b0000, 33};
        vecs[18] = '{4'b1100, 32'h00000064, 32'h00000007, 32'h00000002, 4'b0000, 33};
        vecs[19] = '{4'b1001, 32'h00010000, 32'h00010000, 32'h00000000, 4'b1000, 33};
        vecs[20] = '{4'b1010, 32'h00010000, 32'h00010000, 32'h00000001, 4'b0000, 33};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'h0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", 64'({out_valid, zf, sf, cf, of}), 64'(0));
        check("reset result", 64'(result), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset in_ready", 64'(in_ready), 64'(1));

        for (int i = 0; i < 21; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags, vecs[i].lat,
                   $sformatf("vec%0d", i));
        end

        // Output stall: SUB 0-1 held for five cycles with out_ready low
        @(negedge clk);
        in_valid = 1'b1;
        op       = 4'b1000;
        a        = 32'h0;
        b        = 32'h1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = 32'h12345678;
        b        = 32'h9ABCDEF0;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("stall latency", 64'(lat), 64'(1));
        hold_res = 32'hFFFFFFFF;
        hold_fl  = 4'b0110;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            check($sformatf("stall%0d result", k), 64'(result), 64'(hold_res));
            check($sformatf("stall%0d flags", k), 64'({zf, sf, cf, of}), 64'(hold_fl));
            check($sformatf("stall%0d handshake", k), 64'({out_valid, in_ready}), 64'(2'b10));
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("stall release", 64'({out_valid, in_ready}), 64'(2'b01));

        // Asynchronous reset in the middle of a DIVU
        @(negedge clk);
        in_valid = 1'b1;
        op       = 4'b1011;
        a        = 32'd100;
        b        = 32'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("mid-div busy", 64'({out_valid, in_ready}), 64'(2'b00));
        #1 rst_n = 1'b0;
        #1;
        check("async reset result", 64'(result), 64'(0));
        check("async reset flags", 64'({out_valid, zf, sf, cf, of}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'b1011, 32'd100, 32'd7, 32'd14, 4'b0000, 33, "div after reset");
        run_op(4'b0000, 32'd2, 32'd3, 32'd5, 4'b0000, 1, "add after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_seq_mdu
`default_nettype wire
